branch_predict_unit: RTL and testbench
======================================

# branch_predict_unit

Parametrised branch unit for the pipelined RV32I core. It resolves conditional branches in EX for any `XLEN` and flags mispredictions. It also holds a PC-indexed table of saturating counters that gives IF a taken/not-taken prediction, and it keeps saturating branch and mispredict statistics. It sits between the IF next-PC mux, which consumes `pred_taken`, and the EX-stage hazard/flush logic, which consumes `br` and `mispredict`.

## Interface
- `XLEN`, 32: operand and PC width.
- `BHT_DEPTH`, 64: counter entries; power of two, at least 2.
- `CNT_BITS`, 2: counter width; at least 1.
- `STAT_BITS`, 32: statistics counter width.
- `clk` input 1: clock. One clock domain.
- `rst_n` input 1: synchronous reset, active low.
- `if_pc` input XLEN: PC of the fetch-stage instruction.
- `pred_taken` output 1: prediction for `if_pc`, combinational.
- `ex_valid` input 1: the EX instruction is valid and not being flushed.
- `ex_stall` input 1: EX is held this cycle.
- `ex_pc` input XLEN: PC of the EX instruction.
- `ex_pred_taken` input 1: `pred_taken` value carried down the pipeline with that instruction.
- `reg1`, `reg2` input XLEN: compare operands.
- `br_type` input 3: branch type, encoded per the Parameters.v codes `NOBRANCH`/`BEQ`/`BNE`/`BLT`/`BLTU`/`BGE`/`BGEU`.
- `br` output 1: resolved branch outcome, combinational.
- `mispredict` output 1: resolved outcome differs from the prediction, combinational.
- `branch_cnt` output STAT_BITS: number of resolved conditional branches.
- `mispredict_cnt` output STAT_BITS: number of mispredicts.

## Operation
- Index: `idx = pc[IDXW+1:2]`, where `IDXW = $clog2(BHT_DEPTH)`. The PC is word-aligned, so bits [1:0] are ignored.
- Prediction: `pred_taken` is the MSB of `bht[idx(if_pc)]`.
- Decision (`br`):
  - `BEQ`/`BNE`: compare for equality / inequality.
  - `BLT`/`BGE`: signed compare over the full XLEN.
  - `BLTU`/`BGEU`: unsigned compare over the full XLEN.
  - `NOBRANCH` and any undefined code give `br=0`.
- Decision does not depend on `ex_valid`.
- `is_br` is true when `br_type` is one of the six conditional codes.
- Update enable: `upd = ex_valid & ~ex_stall & is_br`.
- `mispredict = ex_valid & is_br & (br != ex_pred_taken)`. It is not gated by stall, so hazard logic sees it while EX is held.
- Counter update on `upd`:
  - `br=1`: counter increments and saturates at `2^CNT_BITS-1`.
  - `br=0`: counter decrements and saturates at 0.
- Statistics on `upd`:
  - `branch_cnt` increments by 1 and saturates at all-ones.
  - `mispredict_cnt` increments when `mispredict` is also true, with the same saturation.
- Aliasing: PCs that share an index share a counter. No tags.
- Targets are not predicted. Target generation and the BTB are outside this block.

## Timing
- Reset, while `rst_n=0` at a rising edge:
  - every counter loads weakly not-taken, `2^(CNT_BITS-1)-1`; with `CNT_BITS=1` this is 0.
  - `branch_cnt` and `mispredict_cnt` load 0.
  - So `pred_taken=0` on the first cycle after reset.
- During reset: table and statistics do not update. The combinational outputs `br`, `mispredict` and `pred_taken` keep following their inputs.
- Reset mid-operation: an update presented in the same cycle as reset is dropped, and the reset value wins.
- `br` and `mispredict` have zero latency; they are valid in the same cycle as their inputs.
- Counter and statistics updates are written at the rising edge that ends the `upd` cycle.
- Same-index read/write in one cycle (`idx(if_pc)==idx(ex_pc)` with `upd`):
  - `pred_taken` returns the pre-update value. No bypass.
  - The new value is visible from the next cycle.
- `ex_stall=1`: no table or statistics change. A branch held for N cycles is counted exactly once, on its unstalled cycle.
- `ex_valid=0`: no update, and `mispredict=0`.

## Structure
- Parameters.v shared include holds the branch type codes, and gains `BHT_WEAK_NT` as the counter reset value.
- One sub-module, `branch_compare`: combinational XLEN comparator taking `br_type` and producing `br` and `is_br`.
- The top level contains:
  - the counter array, as a flop array so the synchronous reset clears it in one cycle;
  - the index math;
  - the saturating statistic counters.
- Expected size is about 150–250 lines.

## Test plan
- **Reset:** hold `rst_n=0` for 2 cycles, then release with `if_pc` swept over all indices. Required: `pred_taken=0` everywhere, `branch_cnt=0`, `mispredict_cnt=0`.
- **Compare corners** (`XLEN=32`, `reg1=0x80000000`, `reg2=0x00000001`):
  - `BLT` gives `br=1`; `BLTU` gives 0; `BGE` gives 0; `BGEU` gives 1.
  - Equal operands: `BEQ` gives 1, `BNE` gives 0.
  - `br_type=3'b111` gives `br=0` with no update.
- **Training:** apply 3 taken `BEQ` at `ex_pc=0x100` with `ex_pred_taken=0`. Required:
  - the counter goes 1→2→3→3;
  - `pred_taken` for `if_pc=0x100` goes 1 after the first update;
  - `mispredict` pulses 3 times because prediction was held at 0;
  - `branch_cnt=3`.
- **Stall and flush:** hold a mispredicted branch with `ex_stall=1` for 4 cycles, then release. Required:
  - `mispredict=1` for all 5 cycles;
  - `mispredict_cnt` increments once.
  - A branch with `ex_valid=0` leaves all state unchanged.
- **Collision:** `if_pc=0x004` and `ex_pc=0x104` share an index with `BHT_DEPTH=64`; present a taken update from counter 1 in the same cycle. Required: `pred_taken=0` that cycle and 1 the next.
- **Saturation:** run with `STAT_BITS=4` and 20 mispredicted branches. Required: both statistics stop at 15.

Source files
------------

// File: rtl/branch_predict_unit_pkg.sv
// Shared definitions for the branch unit.
//  - br_type_e      : branch type codes carried on br_type (3 bits)
//  - is_cond_branch : true for the six conditional compare codes
//  - bht_weak_nt    : counter reset value (weakly not-taken) for a given width
package branch_predict_unit_pkg;

  typedef enum logic [2:0] {
    NOBRANCH = 3'd0,
    BEQ      = 3'd1,
    BNE      = 3'd2,
    BLT      = 3'd3,
    BLTU     = 3'd4,
    BGE      = 3'd5,
    BGEU     = 3'd6
  } br_type_e;

  function automatic logic is_cond_branch(input logic [2:0] code);
    return (code == BEQ) || (code == BNE) || (code == BLT) ||
           (code == BLTU) || (code == BGE) || (code == BGEU);
  endfunction

  // 2^(cnt_bits-1)-1 : the highest not-taken value; 0 for a 1-bit counter.
  function automatic int unsigned bht_weak_nt(input int unsigned cnt_bits);
    return (32'd1 << (cnt_bits - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Bundle between the branch unit and the IF / EX pipeline stages.
//  IF side : if_pc -> pred_taken
//  EX side : ex_valid, ex_stall, ex_pc, ex_pred_taken, reg1, reg2, br_type
//            -> br, mispredict
//  Stats   : branch_cnt, mispredict_cnt
// master = pipeline side, slave = branch_predict_unit.
interface branch_predict_unit_if #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned STAT_BITS = 32
);
  logic [XLEN-1:0]      if_pc;
  logic                 pred_taken;
  logic                 ex_valid;
  logic                 ex_stall;
  logic [XLEN-1:0]      ex_pc;
  logic                 ex_pred_taken;
  logic [XLEN-1:0]      reg1;
  logic [XLEN-1:0]      reg2;
  logic [2:0]           br_type;
  logic                 br;
  logic                 mispredict;
  logic [STAT_BITS-1:0] branch_cnt;
  logic [STAT_BITS-1:0] mispredict_cnt;

  modport master (
    output if_pc, ex_valid, ex_stall, ex_pc, ex_pred_taken, reg1, reg2, br_type,
    input  pred_taken, br, mispredict, branch_cnt, mispredict_cnt
  );

  modport slave (
    input  if_pc, ex_valid, ex_stall, ex_pc, ex_pred_taken, reg1, reg2, br_type,
    output pred_taken, br, mispredict, branch_cnt, mispredict_cnt
  );
endinterface

// File: rtl/branch_predict_unit_branch_compare.sv
// branch_compare: combinational XLEN-wide branch condition evaluation.
//  br_type, reg1, reg2 -> br (outcome), is_br (br_type is a conditional code)
// NOBRANCH and undefined codes resolve to br=0, is_br=0.
module branch_compare
  import branch_predict_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      br_type,
  input  logic [XLEN-1:0] reg1,
  input  logic [XLEN-1:0] reg2,
  output logic            br,
  output logic            is_br
);

  always_comb begin
    br    = 1'b0;
    is_br = is_cond_branch(br_type);
    case (br_type)
      BEQ:     br = (reg1 == reg2);
      BNE:     br = (reg1 != reg2);
      BLT:     br = ($signed(reg1) <  $signed(reg2));
      BGE:     br = ($signed(reg1) >= $signed(reg2));
      BLTU:    br = (reg1 <  reg2);
      BGEU:    br = (reg1 >= reg2);
      default: br = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: EX-stage branch resolution plus a PC-indexed table of
// saturating counters predicting taken/not-taken for IF, and saturating
// branch / mispredict statistics.
//  clk, rst_n : clock, synchronous active-low reset
//  bus        : branch_predict_unit_if slave (IF prediction, EX resolution, stats)
// Table read for IF has no bypass: a same-cycle update to the same entry
// becomes visible on the following cycle.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BHT_DEPTH = 64,
  parameter int unsigned CNT_BITS  = 2,
  parameter int unsigned STAT_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_predict_unit_if.slave bus
);

  localparam int unsigned IDXW = $clog2(BHT_DEPTH);
  localparam logic [CNT_BITS-1:0] BHT_WEAK_NT = CNT_BITS'(bht_weak_nt(CNT_BITS));

  logic [CNT_BITS-1:0]  bht [BHT_DEPTH];
  logic [IDXW-1:0]      if_idx;
  logic [IDXW-1:0]      ex_idx;
  logic                 br;
  logic                 is_br;
  logic                 upd;
  logic                 mispredict;
  logic [CNT_BITS-1:0]  ex_cnt;
  logic [CNT_BITS-1:0]  ex_cnt_nxt;
  logic [STAT_BITS-1:0] branch_cnt;
  logic [STAT_BITS-1:0] mispredict_cnt;
  logic                 unused_pc_bits;

  // Word-aligned PCs: bits [1:0] and the bits above the index are not used.
  assign if_idx         = bus.if_pc[IDXW+1:2];
  assign ex_idx         = bus.ex_pc[IDXW+1:2];
  assign unused_pc_bits = ^{bus.if_pc, bus.ex_pc};

  branch_compare #(.XLEN(XLEN)) u_branch_compare (
    .br_type (bus.br_type),
    .reg1    (bus.reg1),
    .reg2    (bus.reg2),
    .br      (br),
    .is_br   (is_br)
  );

  // Mispredict is deliberately not gated by stall so hazard logic sees it
  // for every cycle the branch sits in EX; only the update is stall-gated.
  assign upd        = bus.ex_valid & ~bus.ex_stall & is_br;
  assign mispredict = bus.ex_valid & is_br & (br != bus.ex_pred_taken);

  always_comb begin
    ex_cnt     = bht[ex_idx];
    ex_cnt_nxt = ex_cnt;
    if (br) begin
      if (ex_cnt != '1) ex_cnt_nxt = ex_cnt + 1'b1;
    end else begin
      if (ex_cnt != '0) ex_cnt_nxt = ex_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BHT_DEPTH; i++) bht[i] <= BHT_WEAK_NT;
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else if (upd) begin
      bht[ex_idx] <= ex_cnt_nxt;
      if (branch_cnt != '1) branch_cnt <= branch_cnt + 1'b1;
      if (mispredict && (mispredict_cnt != '1)) mispredict_cnt <= mispredict_cnt + 1'b1;
    end
  end

  assign bus.pred_taken     = bht[if_idx][CNT_BITS-1];
  assign bus.br             = br;
  assign bus.mispredict     = mispredict;
  assign bus.branch_cnt     = branch_cnt;
  assign bus.mispredict_cnt = mispredict_cnt;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit with BHT_DEPTH=64, CNT_BITS=2, STAT_BITS=4.
// Reference model: integer counter table and integer statistics clamped with
// plain arithmetic; predictions are "counter >= 2".
module tb_branch_predict_unit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 64;
  localparam int SMAX  = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_predict_unit_if #(.XLEN(XLEN), .STAT_BITS(4)) bus ();

  branch_predict_unit #(
    .XLEN      (XLEN),
    .BHT_DEPTH (DEPTH),
    .CNT_BITS  (2),
    .STAT_BITS (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  int m_bht [DEPTH];
  int m_bcnt;
  int m_mcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_br(input int t, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (t)
      1: return ua == ub;
      2: return ua != ub;
      3: return sa < sb;
      4: return ua < ub;
      5: return sa >= sb;
      6: return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit ref_isbr(input int t);
    return (t >= 1) && (t <= 6);
  endfunction

  function automatic int ref_idx(input logic [31:0] pc);
    return int'((pc / 4) % DEPTH);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_bht[i] = 1;
    m_bcnt = 0;
    m_mcnt = 0;
  endtask

  // Compare all outputs against the model at the negative edge.
  task automatic sample();
    bit eb, em;
    @(negedge clk);
    eb = ref_br(int'(bus.br_type), bus.reg1, bus.reg2);
    em = bus.ex_valid && ref_isbr(int'(bus.br_type)) && (eb != bus.ex_pred_taken);
    chk("br", {31'd0, bus.br}, {31'd0, eb});
    chk("mispredict", {31'd0, bus.mispredict}, {31'd0, em});
    chk("pred_taken", {31'd0, bus.pred_taken}, (m_bht[ref_idx(bus.if_pc)] >= 2) ? 32'd1 : 32'd0);
    chk("branch_cnt", {28'd0, bus.branch_cnt}, 32'(m_bcnt));
    chk("mispredict_cnt", {28'd0, bus.mispredict_cnt}, 32'(m_mcnt));
  endtask

  // Apply the rising edge to the model, then return 1 time unit later.
  task automatic adv();
    bit eb, em;
    int k;
    @(posedge clk);
    eb = ref_br(int'(bus.br_type), bus.reg1, bus.reg2);
    em = bus.ex_valid && ref_isbr(int'(bus.br_type)) && (eb != bus.ex_pred_taken);
    if (!rst_n) begin
      model_reset();
    end else if (bus.ex_valid && !bus.ex_stall && ref_isbr(int'(bus.br_type))) begin
      k = ref_idx(bus.ex_pc);
      m_bht[k] = eb ? ((m_bht[k] < 3) ? m_bht[k] + 1 : 3) : ((m_bht[k] > 0) ? m_bht[k] - 1 : 0);
      m_bcnt = (m_bcnt < SMAX) ? m_bcnt + 1 : SMAX;
      if (em) m_mcnt = (m_mcnt < SMAX) ? m_mcnt + 1 : SMAX;
    end
    #1;
  endtask

  task automatic set_ex(input bit v, input bit s, input logic [31:0] pc, input bit pt,
                        input logic [31:0] a, input logic [31:0] b, input logic [2:0] t);
    bus.ex_valid      = v;
    bus.ex_stall      = s;
    bus.ex_pc         = pc;
    bus.ex_pred_taken = pt;
    bus.reg1          = a;
    bus.reg2          = b;
    bus.br_type       = t;
  endtask

  initial begin
    int exp_pred [3];
    int old_m;
    logic [2:0] corner_t [6];
    logic [31:0] corner_a [6];
    logic [31:0] corner_b [6];
    logic corner_e [6];

    // Reset: two cycles low, then sweep every index.
    rst_n = 1'b0;
    bus.if_pc = '0;
    set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0);
    model_reset();
    @(posedge clk); #1;
    sample(); adv();
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.if_pc = 32'(i * 4);
      sample();
      chk("reset_pred", {31'd0, bus.pred_taken}, 32'd0);
      adv();
    end
    chk("reset_bcnt", {28'd0, bus.branch_cnt}, 32'd0);
    chk("reset_mcnt", {28'd0, bus.mispredict_cnt}, 32'd0);

    // Compare corners (no update: ex_valid=0).
    corner_t = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd1, 3'd2};
    corner_a = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h1234, 32'h1234};
    corner_b = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h1234, 32'h1234};
    corner_e = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      set_ex(1'b0, 1'b0, 32'h40, 1'b0, corner_a[i], corner_b[i], corner_t[i]);
      sample();
      chk($sformatf("corner%0d", i), {31'd0, bus.br}, {31'd0, corner_e[i]});
      adv();
    end
    // Undefined code with ex_valid=1: br=0, no mispredict, no update.
    set_ex(1'b1, 1'b0, 32'h40, 1'b1, 32'h5, 32'h5, 3'b111);
    sample();
    chk("undef_br", {31'd0, bus.br}, 32'd0);
    chk("undef_misp", {31'd0, bus.mispredict}, 32'd0);
    adv();
    set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0);
    sample();
    chk("undef_bcnt", {28'd0, bus.branch_cnt}, 32'd0);
    adv();

    // Training: three taken BEQ at 0x100, prediction held at 0.
    exp_pred = '{0, 1, 1};
    bus.if_pc = 32'h100;
    for (int i = 0; i < 3; i++) begin
      set_ex(1'b1, 1'b0, 32'h100, 1'b0, 32'h77, 32'h77, 3'd1);
      sample();
      chk($sformatf("train_pred%0d", i), {31'd0, bus.pred_taken}, 32'(exp_pred[i]));
      chk($sformatf("train_misp%0d", i), {31'd0, bus.mispredict}, 32'd1);
      adv();
    end
    set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0);
    sample();
    chk("train_pred_after", {31'd0, bus.pred_taken}, 32'd1);
    chk("train_bcnt", {28'd0, bus.branch_cnt}, 32'd3);
    adv();
    // One not-taken from a saturated 3 keeps the prediction taken.
    set_ex(1'b1, 1'b0, 32'h100, 1'b1, 32'h1, 32'h2, 3'd1);
    sample(); adv();
    set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0);
    sample();
    chk("train_sat_pred", {31'd0, bus.pred_taken}, 32'd1);
    adv();

    // Stall: mispredicted BNE held 4 cycles, then released.
    old_m = m_mcnt;
    set_ex(1'b1, 1'b1, 32'h200, 1'b1, 32'h9, 32'h9, 3'd2);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) bus.ex_stall = 1'b0;
      sample();
      chk($sformatf("stall_misp%0d", i), {31'd0, bus.mispredict}, 32'd1);
      chk($sformatf("stall_mcnt%0d", i), {28'd0, bus.mispredict_cnt}, 32'(old_m));
      adv();
    end
    set_ex(1'b0, 1'b0, 32'h200, 1'b1, 32'h9, 32'h9, 3'd2);
    sample();
    chk("stall_mcnt_once", {28'd0, bus.mispredict_cnt}, 32'(old_m + 1));
    adv();
    // Flushed branch (ex_valid=0): no mispredict, state unchanged.
    sample();
    chk("flush_misp", {31'd0, bus.mispredict}, 32'd0);
    adv();
    sample(); adv();

    // Collision: if_pc 0x004 and ex_pc 0x104 share index 1 (counter 1).
    bus.if_pc = 32'h004;
    set_ex(1'b1, 1'b0, 32'h104, 1'b0, 32'h3, 32'h3, 3'd1);
    sample();
    chk("collide_same", {31'd0, bus.pred_taken}, 32'd0);
    adv();
    set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0);
    sample();
    chk("collide_next", {31'd0, bus.pred_taken}, 32'd1);
    adv();

    // Saturation: 20 mispredicted branches with 4-bit statistics.
    for (int i = 0; i < 20; i++) begin
      set_ex(1'b1, 1'b0, 32'(32'h300 + i * 4), 1'b1, 32'h1, 32'h2, 3'd1);
      sample(); adv();
    end
    set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0);
    sample();
    chk("sat_bcnt", {28'd0, bus.branch_cnt}, 32'd15);
    chk("sat_mcnt", {28'd0, bus.mispredict_cnt}, 32'd15);
    adv();

    // Random traffic against the reference model, with occasional resets.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = ~a;
        2: b = {a[31:8], 8'($urandom)};
        default: b = $urandom;
      endcase
      rst_n     = ($urandom_range(0, 39) != 0);
      bus.if_pc = {22'($urandom), 8'($urandom_range(0, 15) * 4), 2'b00} ^ 32'(($urandom_range(0, 3)) << 2);
      set_ex($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
             {22'($urandom), 8'($urandom_range(0, 15) * 4), 2'b00},
             1'($urandom), a, b, 3'($urandom));
      sample(); adv();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
